pit_lookup: RTL and testbench

- Sits directly upstream of the PIT memory-transfer stage.
- Receives name hashes of arriving interest and data packets from the packet parser and keeps a small associative table of pending interests.
- Produces the 11-bit table entry plus in/out strobes that the PIT stage consumes to write or read the packet-memory slot.
- Each matched entry maps to a fixed 10-bit packet-memory base address.

---
 rtl/pit_pkg.sv | 25 ++
 rtl/pit_entry_array.sv | 55 +++++
 rtl/pit_lookup.sv | 200 ++++++++++++++++++++
 tb/tb_pit_lookup.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// Shared types and helpers for the pending-interest table lookup block.
package pit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_RESPOND
    } state_e;

    localparam logic REQ_INTEREST = 1'b0;
    localparam logic REQ_DATA     = 1'b1;

    localparam int PIT_ADDR_W   = 10;
    localparam int RECEIVED_BIT = PIT_ADDR_W;
    localparam int MAX_IDX_W    = 6;

    // Each entry owns an equal power-of-two slice of packet memory.
    function automatic logic [PIT_ADDR_W-1:0] slot_base(input logic [MAX_IDX_W-1:0] idx,
                                                        input int idx_w);
        logic [PIT_ADDR_W-1:0] base;
        base = PIT_ADDR_W'(idx) << (PIT_ADDR_W - idx_w);
        return base;
    endfunction

endpackage

// File: rtl/pit_entry_array.sv
// Register file of pending interests: one combinational read port plus a
// single set/clear write port, both addressed by entry index.
module pit_entry_array
    import pit_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int HASH_W  = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [HASH_W-1:0] rd_hash,
    input  logic              set_en,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [HASH_W-1:0] wr_hash
);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [HASH_W-1:0]  hash_q [ENTRIES];
    logic [HASH_W-1:0]  hash_d [ENTRIES];

    // NOTE: every _d starts from its _q copy so no path leaves it unassigned (no latches).
    always_comb begin
        valid_d = valid_q;
        hash_d  = hash_q;
        if (set_en) begin
            valid_d[wr_idx] = 1'b1;
            hash_d[wr_idx]  = wr_hash;
        end else if (clr_en) begin
            valid_d[wr_idx] = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the hash store is deliberately not reset; valid_q gates every use of it.
    always_ff @(posedge clk) begin
        hash_q <= hash_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_hash  = hash_q[rd_idx];

endmodule

// File: rtl/pit_lookup.sv
// Pending-interest table lookup: a sequential scan over the entry array that
// allocates, aggregates or retires entries and hands the slot to the PIT stage.
module pit_lookup
    import pit_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int HASH_W  = 16,
    parameter int ADDR_W  = PIT_ADDR_W,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_type,
    input  logic [HASH_W-1:0] req_hash,
    output logic [ADDR_W:0]   table_entry,
    output logic              in_bit,
    output logic              out_bit,
    output logic              interest_packet,
    output logic              aggregated,
    output logic              full_drop,
    output logic [IDX_W:0]    occupancy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              type_q, type_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
    logic              free_q, free_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic [IDX_W:0]    occ_q, occ_d;
    logic [ADDR_W:0]   table_entry_q, table_entry_d;
    logic              ready_q, ready_d;
    logic              in_q, in_d;
    logic              out_q, out_d;
    logic              agg_q, agg_d;
    logic              full_q, full_d;

    logic              rd_valid;
    logic [HASH_W-1:0] rd_hash;
    logic              set_en;
    logic              clr_en;
    logic [IDX_W-1:0]  wr_idx;

    pit_entry_array #(
        .ENTRIES (ENTRIES),
        .HASH_W  (HASH_W)
    ) u_entries (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_q),
        .rd_valid (rd_valid),
        .rd_hash  (rd_hash),
        .set_en   (set_en),
        .clr_en   (clr_en),
        .wr_idx   (wr_idx),
        .wr_hash  (hash_q)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        type_d        = type_q;
        hash_d        = hash_q;
        hit_d         = hit_q;
        hit_idx_d     = hit_idx_q;
        free_d        = free_q;
        free_idx_d    = free_idx_q;
        occ_d         = occ_q;
        table_entry_d = table_entry_q;
        in_d          = 1'b0;
        out_d         = 1'b0;
        agg_d         = 1'b0;
        full_d        = 1'b0;
        set_en        = 1'b0;
        clr_en        = 1'b0;
        wr_idx        = free_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    type_d     = req_type;
                    hash_d     = req_hash;
                    idx_d      = '0;
                    hit_d      = 1'b0;
                    hit_idx_d  = '0;
                    free_d     = 1'b0;
                    free_idx_d = '0;
                    state_d    = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
                // Earliest index wins for both the match and the free slot.
                if (!hit_q && rd_valid && (rd_hash == hash_q)) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (!free_q && !rd_valid) begin
                    free_d     = 1'b1;
                    free_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_RESPOND;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_RESPOND: begin
                state_d = ST_IDLE;
                if (type_q == REQ_INTEREST) begin
                    if (hit_q) begin
                        agg_d = 1'b1;
                    end else if (free_q) begin
                        set_en        = 1'b1;
                        wr_idx        = free_idx_q;
                        occ_d         = occ_q + (IDX_W+1)'(1);
                        table_entry_d = {1'b1, ADDR_W'(slot_base(MAX_IDX_W'(free_idx_q), IDX_W))};
                        in_d          = 1'b1;
                    end else begin
                        full_d        = 1'b1;
                        table_entry_d = '0;
                    end
                end else begin
                    out_d = 1'b1;
                    if (hit_q) begin
                        clr_en        = 1'b1;
                        wr_idx        = hit_idx_q;
                        occ_d         = occ_q - (IDX_W+1)'(1);
                        table_entry_d = {1'b1, ADDR_W'(slot_base(MAX_IDX_W'(hit_idx_q), IDX_W))};
                    end else begin
                        table_entry_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready tracks the state being entered, so it is low for the
        // first cycle after reset release and high exactly while in IDLE.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            type_q        <= REQ_INTEREST;
            hash_q        <= '0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            free_q        <= 1'b0;
            free_idx_q    <= '0;
            occ_q         <= '0;
            table_entry_q <= '0;
            ready_q       <= 1'b0;
            in_q          <= 1'b0;
            out_q         <= 1'b0;
            agg_q         <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            type_q        <= type_d;
            hash_q        <= hash_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            free_q        <= free_d;
            free_idx_q    <= free_idx_d;
            occ_q         <= occ_d;
            table_entry_q <= table_entry_d;
            ready_q       <= ready_d;
            in_q          <= in_d;
            out_q         <= out_d;
            agg_q         <= agg_d;
            full_q        <= full_d;
        end
    end

    assign req_ready       = ready_q;
    assign table_entry     = table_entry_q;
    assign in_bit          = in_q;
    assign out_bit         = out_q;
    assign aggregated      = agg_q;
    assign full_drop       = full_q;
    assign occupancy       = occ_q;
    // Reserved for the FIB path; this block only ever stores new interests.
    assign interest_packet = 1'b0;

endmodule

// File: tb/tb_pit_lookup.sv
// Self-checking bench for pit_lookup: vector table plus scoreboard queue.
module tb_pit_lookup;

    localparam int ENTRIES = 32;
    localparam int HASH_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int STROBE_EDGES = ENTRIES + 1;

    typedef struct {
        logic              typ;
        logic [HASH_W-1:0] hash;
        logic              e_in;
        logic              e_out;
        logic              e_agg;
        logic              e_full;
        logic              chk_te;
        logic [ADDR_W:0]   e_te;
        logic [6:0]        e_occ;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_type;
    logic [HASH_W-1:0] req_hash;
    logic [ADDR_W:0]   table_entry;
    logic              in_bit;
    logic              out_bit;
    logic              interest_packet;
    logic              aggregated;
    logic              full_drop;
    logic [5:0]        occupancy;

    int   n_vec;
    int   n_err;
    vec_t sb[$];

    pit_lookup #(
        .ENTRIES (ENTRIES),
        .HASH_W  (HASH_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_type        (req_type),
        .req_hash        (req_hash),
        .table_entry     (table_entry),
        .in_bit          (in_bit),
        .out_bit         (out_bit),
        .interest_packet (interest_packet),
        .aggregated      (aggregated),
        .full_drop       (full_drop),
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic typ, input logic [HASH_W-1:0] hash,
                                input logic e_in, input logic e_out, input logic e_agg,
                                input logic e_full, input logic chk_te,
                                input logic [ADDR_W:0] e_te, input int e_occ);
        vec_t v;
        v.typ = typ; v.hash = hash;
        v.e_in = e_in; v.e_out = e_out; v.e_agg = e_agg; v.e_full = e_full;
        v.chk_te = chk_te; v.e_te = e_te; v.e_occ = 7'(e_occ);
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (req_ready === 1'b1);
    endtask

    // Issue one request, then compare the strobe cycle against the scoreboard head.
    task automatic run_req(input vec_t v);
        bit   ok;
        bit   seen;
        int   lat;
        vec_t e;
        wait_ready(ok);
        if (!ok) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_type  = v.typ;
        req_hash  = v.hash;
        @(posedge clk);
        sb.push_back(v);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= ENTRIES + 8 && !seen; n++) begin
            @(posedge clk); #1;
            if (in_bit || out_bit || aggregated || full_drop) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        if (!seen) begin
            check("strobe_timeout", 32'(seen), 32'd1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(STROBE_EDGES));
        check("in_bit", 32'(in_bit), 32'(e.e_in));
        check("out_bit", 32'(out_bit), 32'(e.e_out));
        check("aggregated", 32'(aggregated), 32'(e.e_agg));
        check("full_drop", 32'(full_drop), 32'(e.e_full));
        check("interest_packet", 32'(interest_packet), 32'd0);
        if (e.chk_te) check("table_entry", 32'(table_entry), 32'(e.e_te));
        check("occupancy", 32'(occupancy), 32'(e.e_occ));
        @(posedge clk); #1;
        check("strobe_width", 32'({in_bit, out_bit, aggregated, full_drop}), 32'd0);
        if (e.chk_te) check("table_entry_hold", 32'(table_entry), 32'(e.e_te));
    endtask

    vec_t vecs[9];

    initial begin
        bit ok;
        int strobes;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_type  = 1'b0;
        req_hash  = '0;

        vecs[0] = mk(1'b0, 16'h1234, 1, 0, 0, 0, 1, 11'h400, 1);
        vecs[1] = mk(1'b0, 16'h1234, 0, 0, 1, 0, 0, 11'h000, 1);
        vecs[2] = mk(1'b0, 16'hBEEF, 1, 0, 0, 0, 1, 11'h420, 2);
        vecs[3] = mk(1'b1, 16'h1234, 0, 1, 0, 0, 1, 11'h400, 1);
        vecs[4] = mk(1'b0, 16'h5555, 1, 0, 0, 0, 1, 11'h400, 2);
        vecs[5] = mk(1'b1, 16'hBEEF, 0, 1, 0, 0, 1, 11'h420, 1);
        vecs[6] = mk(1'b1, 16'h5555, 0, 1, 0, 0, 1, 11'h400, 0);
        vecs[7] = mk(1'b1, 16'hAAAA, 0, 1, 0, 0, 1, 11'h000, 0);
        vecs[8] = mk(1'b1, 16'h1234, 0, 1, 0, 0, 1, 11'h000, 0);

        // Reset state and the one-cycle-late ready after release.
        #12;
        check("rst_outputs", 32'({in_bit, out_bit, aggregated, full_drop, interest_packet}), 32'd0);
        check("rst_table_entry", 32'(table_entry), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        #10 reset = 1'b1;
        #1 check("ready_before_clock", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_clock", 32'(req_ready), 32'd1);

        foreach (vecs[i]) run_req(vecs[i]);

        // Fill every entry in index order, then overflow.
        for (int i = 0; i < ENTRIES; i++) begin
            run_req(mk(1'b0, 16'(16'h1000 + i), 1, 0, 0, 0, 1, 11'h400 | 11'(i << 5), i + 1));
        end
        run_req(mk(1'b0, 16'h2000, 0, 0, 0, 1, 1, 11'h000, ENTRIES));
        run_req(mk(1'b1, 16'h101F, 0, 1, 0, 0, 1, 11'h7E0, ENTRIES - 1));
        run_req(mk(1'b0, 16'h3333, 1, 0, 0, 0, 1, 11'h7E0, ENTRIES));

        // Reset lands mid-scan at idx 10: request vanishes and the table empties.
        wait_ready(ok);
        check("abort_ready", 32'(ok), 32'd1);
        req_valid = 1'b1;
        req_type  = 1'b1;
        req_hash  = 16'h1005;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_occupancy", 32'(occupancy), 32'd0);
        check("abort_strobes", 32'({in_bit, out_bit, aggregated, full_drop}), 32'd0);
        check("abort_table_entry", 32'(table_entry), 32'd0);
        check("abort_ready_low", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        strobes = 0;
        for (int n = 0; n < ENTRIES + 8; n++) begin
            @(posedge clk); #1;
            if (in_bit || out_bit || aggregated || full_drop) strobes++;
        end
        check("abort_no_strobe", 32'(strobes), 32'd0);
        run_req(mk(1'b1, 16'h1005, 0, 1, 0, 0, 1, 11'h000, 0));
        run_req(mk(1'b0, 16'h1005, 1, 0, 0, 0, 1, 11'h400, 1));

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
